// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch slice.
//   fetch_state_t    - fetch FSM states (HALT only with FETCH_MISALIGN_EXC_EN)
//   fetch_entry_t    - buffered fetch entry {pc, inst}
//   DEFAULT_RESET_PC - default first fetch address after reset
package fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_MISALIGN_EXC_EN
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT
  } fetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN
  } fetch_state_t;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry buffer between instruction ROM and decode.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push        - write push_data (accepted when not full, or full with a pop)
//   pop         - drop the head entry (ignored when empty)
//   flush       - empty the buffer; takes priority over push/pop
//   push_data   - entry to write
//   count       - number of valid entries (0..2)
//   head        - oldest entry (meaningful only when count != 0)
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         do_push;
  logic         do_pop;

  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: instruction fetch controller with a 2-entry output buffer.
//   clk, rst_n         - clock, asynchronous active-low reset
//   rom_ce, rom_addr   - ROM chip enable and byte address (= current PC)
//   rom_inst           - combinational ROM data for rom_addr
//   redirect_valid/pc  - PC change request (branch/jump/trap); flushes buffer
//   out_valid/ready    - handshake toward decode
//   out_pc, out_inst   - buffered head entry (zero when out_valid=0)
//   misalign_exc       - misaligned redirect flag (FETCH_MISALIGN_EXC_EN only)
// Macro FETCH_MISALIGN_EXC_EN enables misaligned-redirect detection and HALT;
// without it redirect targets are forced to word alignment.
module inst_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        rom_ce,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
`ifdef FETCH_MISALIGN_EXC_EN
  ,
  output logic        misalign_exc
`endif
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pc;
  logic [31:0]  pc_nxt;
  logic [31:0]  tgt_pc;
  logic         pop;
  logic [1:0]   count;
  fetch_entry_t push_data;
  fetch_entry_t head;

`ifdef FETCH_MISALIGN_EXC_EN
  logic misalign;
  assign misalign = (redirect_pc[1:0] != 2'b00);
  assign tgt_pc   = redirect_pc;
`else
  assign tgt_pc   = redirect_pc & 32'hFFFF_FFFC;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    rom_ce    = 1'b0;
    // A redirect discards the head, so it never counts as a transfer.
    pop       = out_valid && out_ready && !redirect_valid;
    case (state)
      ST_IDLE: state_nxt = ST_RUN;
      ST_RUN:  rom_ce = !redirect_valid && ((count != 2'd2) || pop);
      default: ;
    endcase
    if (rom_ce) begin
      pc_nxt = pc + 32'd4;
    end
    if (redirect_valid) begin
      pc_nxt = tgt_pc;
`ifdef FETCH_MISALIGN_EXC_EN
      state_nxt = misalign ? ST_HALT : ST_RUN;
`else
      state_nxt = ST_RUN;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_exc <= 1'b0;
    end else if (redirect_valid) begin
      misalign_exc <= misalign;
    end
  end
`endif

  assign push_data.pc   = pc;
  assign push_data.inst = rom_inst;

  fetch_fifo u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rom_ce),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_data),
    .count     (count),
    .head      (head)
  );

  assign rom_addr  = pc;
  assign out_valid = (count != 2'd0);
  assign out_pc    = out_valid ? head.pc   : '0;
  assign out_inst  = out_valid ? head.inst : '0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
`timescale 1ns/1ps
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef FETCH_MISALIGN_EXC_EN
  logic        misalign_exc;
`endif

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  // Instruction ROM model: distinct word per address.
  function automatic logic [31:0] rom_model(input logic [31:0] a);
    return (a ^ 32'h5A3C_96E1) + {a[15:0], a[31:16]};
  endfunction

  assign rom_inst = rom_model(rom_addr);

  inst_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_ce         (rom_ce),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
`ifdef FETCH_MISALIGN_EXC_EN
    ,
    .misalign_exc   (misalign_exc)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted transfer must match the queue head.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_xfer: got pc %h required no transfer", out_pc);
      end else begin
        e = exp_q.pop_front();
        check("xfer_pc", out_pc, e);
        check("xfer_inst", out_inst, rom_model(e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic peek();
    #3;
  endtask

  task automatic push_seq(input logic [31:0] start, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    exp_q.delete();
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while (exp_q.size() > 2 && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() > 2) begin
      fails++;
      $display("FAIL %s: %0d transfers still pending, required at most 2", name, exp_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset state
    #2;
    check("rst_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_rom_addr", rom_addr, 32'h0);
    step();
    step();

    // Reset release: IDLE for one cycle, then 0,4,8 back to back
    push_seq(32'h0, 8);
    rst_n = 1'b1;
    peek();
    check("idle_rom_ce", {31'd0, rom_ce}, 32'd0);
    step(); peek();
    check("run_rom_ce", {31'd0, rom_ce}, 32'd1);
    check("run_rom_addr", rom_addr, 32'h0);
    step(); peek();
    check("tp_pc0", out_pc, 32'h0);
    step(); peek();
    check("tp_pc4", out_pc, 32'h4);
    step(); peek();
    check("tp_pc8", out_pc, 32'h8);
    wait_drain("drain_reset_seq");

    // PC wrap at top of address space
    redirect(32'hFFFF_FFFC);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    exp_q.push_back(32'h10);
    peek();
    check("wrap_gap_valid", {31'd0, out_valid}, 32'd0);
    check("wrap_rom_addr", rom_addr, 32'hFFFF_FFFC);
    step(); peek();
    check("wrap_first_pc", out_pc, 32'hFFFF_FFFC);
    wait_drain("drain_wrap");

    // Stall: buffer fills to two, rom_ce drops, head stays put
    out_ready = 1'b0;
    redirect(32'h100);
    push_seq(32'h100, 6);
    for (int unsigned i = 0; i < 4; i++) begin
      step(); peek();
      check("stall_head_pc", out_pc, 32'h100);
    end
    check("stall_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("stall_valid", {31'd0, out_valid}, 32'd1);
    check("stall_rom_addr", rom_addr, 32'h108);
    out_ready = 1'b1;
    wait_drain("drain_stall");

    // Redirect with two buffered entries
    out_ready = 1'b0;
    step(); step(); step(); peek();
    check("full_rom_ce", {31'd0, rom_ce}, 32'd0);
    out_ready = 1'b1;
    redirect(32'h40);
    push_seq(32'h40, 6);
    peek();
    check("redir_gap_valid", {31'd0, out_valid}, 32'd0);
    step(); peek();
    check("redir_valid", {31'd0, out_valid}, 32'd1);
    check("redir_pc", out_pc, 32'h40);
    wait_drain("drain_redirect");

`ifdef FETCH_MISALIGN_EXC_EN
    // Misaligned target halts fetch until an aligned redirect
    redirect(32'h42);
    peek();
    check("mis_exc", {31'd0, misalign_exc}, 32'd1);
    check("mis_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("mis_valid", {31'd0, out_valid}, 32'd0);
    step(); peek();
    check("mis_exc_hold", {31'd0, misalign_exc}, 32'd1);
    check("mis_rom_ce_hold", {31'd0, rom_ce}, 32'd0);
    redirect(32'h80);
    push_seq(32'h80, 6);
    peek();
    check("mis_exc_clear", {31'd0, misalign_exc}, 32'd0);
    step(); peek();
    check("mis_resume_pc", out_pc, 32'h80);
    wait_drain("drain_misalign");
`else
    // Low target bits are ignored
    redirect(32'h42);
    push_seq(32'h40, 6);
    peek();
    check("align_rom_addr", rom_addr, 32'h40);
    step(); peek();
    check("align_pc", out_pc, 32'h40);
    wait_drain("drain_align");
`endif

    // Back-to-back redirects: the later target wins
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    exp_q.delete();
    step();
    redirect_pc    = 32'h300;
    exp_q.delete();
    step();
    redirect_valid = 1'b0;
    push_seq(32'h300, 6);
    peek();
    check("b2b_gap_valid", {31'd0, out_valid}, 32'd0);
    check("b2b_rom_addr", rom_addr, 32'h300);
    step(); peek();
    check("b2b_pc", out_pc, 32'h300);
    wait_drain("drain_b2b");

    // Asynchronous reset with a full buffer
    out_ready = 1'b0;
    step(); step(); step(); peek();
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_rom_ce", {31'd0, rom_ce}, 32'd0);
    check("arst_out_pc", out_pc, 32'd0);
    check("arst_rom_addr", rom_addr, 32'h0);
    step();
    out_ready = 1'b1;
    push_seq(32'h0, 6);
    rst_n = 1'b1;
    step(); step(); peek();
    check("restart_pc", out_pc, 32'h0);
    wait_drain("drain_restart");

    rst_n = 1'b0;
    exp_q.delete();
    #20;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/inst_fetch_ctrl.md
INST_FETCH_CTRL -- requirements
Module: inst_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address after reset.
REQ-002 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1, SHALL be the asynchronous, active-low reset.
REQ-004 Port rom_ce, output, 1, SHALL be the instruction ROM chip enable.
REQ-005 Port rom_addr, output, 32, SHALL be the ROM byte address, equal to the current PC.
REQ-006 Port rom_inst, input, 32, SHALL be combinational ROM data for rom_addr, valid in the same cycle.
REQ-007 Port redirect_valid, input, 1, SHALL request a PC change for a branch, jump or trap.
REQ-008 Port redirect_pc, input, 32, SHALL be the redirect target.
REQ-009 Port out_valid, output, 1, SHALL flag a valid fetched instruction toward decode.
REQ-010 Port out_ready, input, 1, SHALL be decode acceptance; a transfer occurs when out_valid && out_ready.
REQ-011 Port out_pc, output, 32, SHALL be the PC of out_inst.
REQ-012 Port out_inst, output, 32, SHALL be the fetched instruction.
REQ-013 Port misalign_exc, output, 1, SHALL flag a misaligned redirect target (present only with FETCH_MISALIGN_EXC_EN).

Function
REQ-014 FSM states SHALL be IDLE, RUN and HALT: IDLE->RUN on the first clock after reset release; RUN->HALT on a misaligned redirect (macro only); HALT->RUN on an aligned redirect.
REQ-015 rom_ce SHALL be 1 only in RUN, in a cycle with no redirect_valid and with a free or simultaneously freed buffer slot; otherwise 0.
REQ-016 Each fetch (rom_ce=1) SHALL push {pc, rom_inst} into a 2-entry FIFO and set pc <= pc+4, mod 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-017 out_valid/out_pc/out_inst SHALL present the FIFO head; latency fetch-to-out_valid is 1 cycle.
REQ-018 A push SHALL be permitted when count<2, or when count==2 and a pop occurs in the same cycle.
REQ-019 Once asserted, out_valid and the head fields SHALL stay stable until the transfer or a redirect.
REQ-020 redirect_valid SHALL, in the same edge, flush the FIFO (count<=0), discard any pop, and load pc <= redirect_pc; the first new instruction appears on out_valid 2 cycles after redirect.
REQ-021 A redirect received in IDLE SHALL still load pc; the state still goes to RUN.
REQ-022 Back-to-back redirects SHALL be honoured in order; the last one wins.
REQ-023 With continuous out_ready=1 and no redirect, throughput SHALL be 1 instruction per cycle.

Reset
REQ-024 While rst_n=0: state=IDLE, pc=RESET_PC, FIFO count=0, rom_ce=0, out_valid=0, out_pc=0, out_inst=0, misalign_exc=0.
REQ-025 Reset asserted mid-operation SHALL discard all buffered instructions immediately, without waiting for a clock edge.

Configuration
REQ-026 With macro FETCH_MISALIGN_EXC_EN defined, a redirect with redirect_pc[1:0]!=0 SHALL still load pc, enter HALT, flush, set misalign_exc=1 until the next aligned redirect, and keep rom_ce=0 in HALT.
REQ-027 Without FETCH_MISALIGN_EXC_EN, the misalign_exc port and HALT state SHALL be absent, and redirect_pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-028 Package fetch_pkg SHALL hold the FSM state enum, the FIFO entry typedef {pc[31:0], inst[31:0]}, and the default RESET_PC constant.
REQ-029 The 2-entry buffer SHALL be sub-module fetch_fifo (push, pop, flush, count, head), instantiated once.

Verification
REQ-030 Reset release with RESET_PC=0 and out_ready=1 -> rom_ce rises 1 cycle after release; out_pc sequence 0,4,8 on consecutive cycles.
REQ-031 out_ready=0 for 5 cycles from the start of fetch -> FIFO holds pc 0 and 4, rom_ce=0, out_pc=0 stable; after out_ready=1, 0,4,8 with no loss or duplicate.
REQ-032 redirect_valid with redirect_pc=32'h40 while 2 entries are buffered -> out_valid=0 next cycle; out_pc=0x40 2 cycles after the redirect; old entries never transferred.
REQ-033 redirect_pc=32'hFFFF_FFFC -> out_pc sequence FFFF_FFFC, 0, 4.
REQ-034 With the macro defined, redirect_pc=32'h42 -> misalign_exc=1, rom_ce=0, out_valid=0; then redirect_pc=32'h80 -> misalign_exc=0, out_pc=0x80.
REQ-035 rst_n pulled low asynchronously with 2 entries buffered -> out_valid=0 and rom_ce=0 before the next clock edge; fetch restarts at RESET_PC.
